ps2_mouse_decoder: RTL and testbench

PS2_MOUSE_DECODER -- requirements
Module: ps2_mouse_decoder

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_frame_check.sv | 24 ++
 rtl/ps2_mouse_decoder.sv | 186 ++++++++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 mouse packet decoder.
//   Frame bit positions of an 11-bit PS/2 frame, status-byte bit positions
//   of the first packet byte, and the decoder FSM state type.
package ps2_pkg;

  // 11-bit frame: start, D0..D7 (D0 nearest the start bit), odd parity, stop.
  localparam int FRAME_W          = 11;
  localparam int FRAME_START_BIT  = 10;
  localparam int FRAME_D0_BIT     = 9;
  localparam int FRAME_PARITY_BIT = 1;
  localparam int FRAME_STOP_BIT   = 0;

  // Status byte (packet byte 1).
  localparam int STAT_LEFT    = 0;
  localparam int STAT_RIGHT   = 1;
  localparam int STAT_MIDDLE  = 2;
  localparam int STAT_ALWAYS1 = 3;
  localparam int STAT_X_SIGN  = 4;
  localparam int STAT_Y_SIGN  = 5;
  localparam int STAT_X_OVF   = 6;
  localparam int STAT_Y_OVF   = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2
  } ps2_state_t;

endpackage

// File: rtl/ps2_frame_check.sv
// ps2_frame_check -- combinational check of one 11-bit PS/2 frame.
//   i_frame : raw frame (start, D0..D7, odd parity, stop)
//   o_byte  : data byte, o_byte[0] = D0
//   o_ok    : start==0, stop==1 and odd parity over data+parity bit
module ps2_frame_check
  import ps2_pkg::*;
(
  input  logic [FRAME_W-1:0] i_frame,
  output logic [7:0]         o_byte,
  output logic               o_ok
);

  // D0 sits just below the start bit, so the byte is bit-reversed on the wire.
  always_comb begin
    o_byte = '0;
    for (int i = 0; i < 8; i++) begin
      o_byte[i] = i_frame[FRAME_D0_BIT - i];
    end
  end

  assign o_ok = ~i_frame[FRAME_START_BIT] & i_frame[FRAME_STOP_BIT] &
                (^{o_byte, i_frame[FRAME_PARITY_BIT]});

endmodule

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder -- turns four captured PS/2 mouse frames into a clamped
// cursor position, button state and optional scroll accumulator.
//   i_clk, i_reset (async, active-high)
//   i_word1..i_word4 : raw frames (status, X delta, Y delta, Z/extra), valid with i_ready
//   i_ready          : one-cycle strobe, four frames available
//   o_x, o_y         : cursor, clamped to 0..H_MAX / 0..V_MAX (0 = top)
//   o_buttons        : {middle, right, left}
//   o_z              : signed scroll accumulator (0 unless wheel enabled)
//   o_valid/o_error  : one-cycle result pulses; o_err_cnt saturating error count
//   o_state          : current FSM state, for debug visibility
// Build option: define PS2_MOUSE_WHEEL_EN to frame-check word4 and accumulate
// its low nibble into o_z; otherwise word4 is ignored and o_z is 0.
//
// Handshake: i_ready is a single-cycle strobe sampled on a rising edge; it is
// accepted only in IDLE, and a strobe seen in CHECK or UPDATE drops that packet
// and pulses o_error on the following cycle.
module ps2_mouse_decoder
  import ps2_pkg::*;
#(
  parameter int H_MAX  = 639,
  parameter int V_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240
)(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [FRAME_W-1:0] i_word1,
  input  logic [FRAME_W-1:0] i_word2,
  input  logic [FRAME_W-1:0] i_word3,
  input  logic [FRAME_W-1:0] i_word4,
  input  logic               i_ready,
  output logic [9:0]         o_x,
  output logic [9:0]         o_y,
  output logic [2:0]         o_buttons,
  output logic [7:0]         o_z,
  output logic               o_valid,
  output logic               o_error,
  output logic [7:0]         o_err_cnt,
  output ps2_state_t         o_state
);

  localparam logic signed [11:0] LP_H_MAX = 12'(H_MAX);
  localparam logic signed [11:0] LP_V_MAX = 12'(V_MAX);

  ps2_state_t         r_state, w_next_state;
  logic [FRAME_W-1:0] r_w1, r_w2, r_w3;
  logic [7:0]         w_status, w_xbyte, w_ybyte;
  logic               w_ok1, w_ok2, w_ok3, w_ok4;
  logic               w_capture, w_drop, w_pkt_ok;
  logic signed [11:0] w_dx, w_dy, r_dx, r_dy;
  logic signed [11:0] w_x_sum, w_y_sum;
  logic [9:0]         w_x_next, w_y_next, r_x, r_y;
  logic [2:0]         r_btn_pend, r_buttons;
  logic               r_ok, r_valid, r_error;
  logic               w_valid_next, w_error_next;
  logic [7:0]         r_err_cnt;

  ps2_frame_check u_chk1 (.i_frame(r_w1), .o_byte(w_status), .o_ok(w_ok1));
  ps2_frame_check u_chk2 (.i_frame(r_w2), .o_byte(w_xbyte),  .o_ok(w_ok2));
  ps2_frame_check u_chk3 (.i_frame(r_w3), .o_byte(w_ybyte),  .o_ok(w_ok3));

  assign w_capture = (r_state == ST_IDLE) & i_ready;
  assign w_drop    = (r_state != ST_IDLE) & i_ready;
  assign w_pkt_ok  = w_ok1 & w_ok2 & w_ok3 & w_ok4 & w_status[STAT_ALWAYS1];

  // 9-bit two's-complement deltas widened to 12 bits; an overflowed axis
  // contributes nothing rather than rejecting the packet.
  assign w_dx = w_status[STAT_X_OVF] ? 12'sd0 :
                {{3{w_status[STAT_X_SIGN]}}, w_status[STAT_X_SIGN], w_xbyte};
  assign w_dy = w_status[STAT_Y_OVF] ? 12'sd0 :
                {{3{w_status[STAT_Y_SIGN]}}, w_status[STAT_Y_SIGN], w_ybyte};

  // Screen Y grows downward while mouse Y grows upward, hence the subtraction.
  assign w_x_sum = $signed({2'b00, r_x}) + r_dx;
  assign w_y_sum = $signed({2'b00, r_y}) - r_dy;

  always_comb begin
    if (w_x_sum[11])              w_x_next = '0;
    else if (w_x_sum > LP_H_MAX)  w_x_next = LP_H_MAX[9:0];
    else                          w_x_next = w_x_sum[9:0];
    if (w_y_sum[11])              w_y_next = '0;
    else if (w_y_sum > LP_V_MAX)  w_y_next = LP_V_MAX[9:0];
    else                          w_y_next = w_y_sum[9:0];
  end

`ifdef PS2_MOUSE_WHEEL_EN
  logic [FRAME_W-1:0] r_w4;
  logic [7:0]         w_zbyte, w_dz, r_dz, r_z;
  logic               w_unused_zhi;

  ps2_frame_check u_chk4 (.i_frame(r_w4), .o_byte(w_zbyte), .o_ok(w_ok4));

  assign w_dz         = {{4{w_zbyte[3]}}, w_zbyte[3:0]};
  assign w_unused_zhi = ^w_zbyte[7:4];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_w4 <= '0;
      r_dz <= '0;
      r_z  <= '0;
    end else begin
      if (w_capture)                    r_w4 <= i_word4;
      if (r_state == ST_CHECK)          r_dz <= w_dz;
      if (r_state == ST_UPDATE && r_ok) r_z  <= r_z + r_dz;
    end
  end

  assign o_z = r_z;
`else
  logic w_unused_word4;

  assign w_unused_word4 = ^i_word4;
  assign w_ok4          = 1'b1;
  assign o_z            = '0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_valid_next = 1'b0;
    w_error_next = w_drop;
    case (r_state)
      ST_IDLE:   if (i_ready) w_next_state = ST_CHECK;
      ST_CHECK:  w_next_state = ST_UPDATE;
      ST_UPDATE: begin
        w_next_state = ST_IDLE;
        w_valid_next = r_ok;
        if (!r_ok) w_error_next = 1'b1;
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Pipeline: capture in IDLE, check results registered in CHECK,
  // outputs and result pulse registered on the edge leaving UPDATE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_w1       <= '0;
      r_w2       <= '0;
      r_w3       <= '0;
      r_ok       <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_btn_pend <= '0;
      r_x        <= 10'(X_INIT);
      r_y        <= 10'(Y_INIT);
      r_buttons  <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_w1 <= i_word1;
        r_w2 <= i_word2;
        r_w3 <= i_word3;
      end
      if (r_state == ST_CHECK) begin
        r_ok       <= w_pkt_ok;
        r_dx       <= w_dx;
        r_dy       <= w_dy;
        r_btn_pend <= {w_status[STAT_MIDDLE], w_status[STAT_RIGHT], w_status[STAT_LEFT]};
      end
      if (r_state == ST_UPDATE && r_ok) begin
        r_x       <= w_x_next;
        r_y       <= w_y_next;
        r_buttons <= r_btn_pend;
      end
      r_valid <= w_valid_next;
      r_error <= w_error_next;
      if (w_error_next && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_x       = r_x;
  assign o_y       = r_y;
  assign o_buttons = r_buttons;
  assign o_valid   = r_valid;
  assign o_error   = r_error;
  assign o_err_cnt = r_err_cnt;
  assign o_state   = r_state;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder -- directed self-checking bench for ps2_mouse_decoder.
// Expected values are hand-computed; wheel expectations follow PS2_MOUSE_WHEEL_EN.
module tb_ps2_mouse_decoder;

`ifdef PS2_MOUSE_WHEEL_EN
  localparam bit WHEEL = 1'b1;
`else
  localparam bit WHEEL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] w1, w2, w3, w4;
  logic        rdy;
  logic [9:0]  o_x, o_y;
  logic [2:0]  o_buttons;
  logic [7:0]  o_z, o_err_cnt;
  logic        o_valid, o_error;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ps2_mouse_decoder dut (
    .i_clk(clk), .i_reset(rst),
    .i_word1(w1), .i_word2(w2), .i_word3(w3), .i_word4(w4),
    .i_ready(rdy),
    .o_x(o_x), .o_y(o_y), .o_buttons(o_buttons), .o_z(o_z),
    .o_valid(o_valid), .o_error(o_error), .o_err_cnt(o_err_cnt),
    .o_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] exp_q[$];
  logic       pre_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Good frame for a data byte: start 0, D0 first, odd parity, stop 1.
  function automatic logic [10:0] fr(input logic [7:0] b);
    logic [10:0] f;
    f     = '0;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1]  = ~(^b);
    f[0]  = 1'b1;
    return f;
  endfunction

  // ---------------- driver ----------------
  // Returns #1 after the second edge following capture (result pulse cycle).
  task automatic pkt(input logic [10:0] a, input logic [10:0] b,
                     input logic [10:0] c, input logic [10:0] d);
    @(negedge clk);
    w1 = a; w2 = b; w3 = c; w4 = d; rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(posedge clk); #1;
    pre_pulse = o_valid | o_error;
    @(posedge clk); #1;
  endtask

  task automatic good(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    pkt(fr(s), fr(x), fr(y), fr(8'h00));
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] exp_x;
  logic [7:0] exp_cnt;
  logic       seen;

  initial begin
    rst = 1'b1; rdy = 1'b0; w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_x",     32'(o_x), 32'd320);
    check("rst_y",     32'(o_y), 32'd240);
    check("rst_btn",   32'(o_buttons), 32'd0);
    check("rst_cnt",   32'(o_err_cnt), 32'd0);
    check("rst_z",     32'(o_z), 32'd0);
    check("rst_pulse", 32'(o_valid | o_error), 32'd0);

    // basic packet
    good(8'h09, 8'h0A, 8'h05);
    check("basic_pre",   32'(pre_pulse), 32'd0);
    check("basic_valid", 32'(o_valid), 32'd1);
    check("basic_err",   32'(o_error), 32'd0);
    check("basic_x",     32'(o_x), 32'd330);
    check("basic_y",     32'(o_y), 32'd235);
    check("basic_btn",   32'(o_buttons), 32'd1);
    @(posedge clk); #1;
    check("basic_1cyc",  32'(o_valid), 32'd0);

    // negative X: -230 then -256 clamps to 0
    good(8'h18, 8'h1A, 8'h00);
    check("negx_x100", 32'(o_x), 32'd100);
    check("negx_btn",  32'(o_buttons), 32'd0);
    good(8'h18, 8'h00, 8'h00);
    check("clamp_x0",  32'(o_x), 32'd0);

    // +255 seven times, clamping at H_MAX
    exp_q = '{10'd255, 10'd510, 10'd639, 10'd639, 10'd639, 10'd639, 10'd639};
    for (int i = 0; i < 7; i++) begin
      good(8'h08, 8'hFF, 8'h00);
      check("clamp_xmax", 32'(o_x), 32'(exp_q.pop_front()));
    end
    check("clamp_y_hold", 32'(o_y), 32'd235);

    // flipped parity on word2
    pkt(fr(8'h08), fr(8'h05) ^ 11'h002, fr(8'h00), fr(8'h00));
    check("par_err",   32'(o_error), 32'd1);
    check("par_valid", 32'(o_valid), 32'd0);
    check("par_cnt",   32'(o_err_cnt), 32'd1);
    check("par_x",     32'(o_x), 32'd639);
    check("par_y",     32'(o_y), 32'd235);

    // X overflow: X ignored, Y applied
    good(8'h48, 8'h10, 8'h01);
    check("ovf_valid", 32'(o_valid), 32'd1);
    check("ovf_x",     32'(o_x), 32'd639);
    check("ovf_y",     32'(o_y), 32'd234);

    // Y clamps: -256 -> V_MAX, then +255 twice -> 0
    good(8'h28, 8'h00, 8'h00);
    check("clamp_ymax", 32'(o_y), 32'd479);
    good(8'h08, 8'h00, 8'hFF);
    check("y_224",      32'(o_y), 32'd224);
    good(8'h08, 8'h00, 8'hFF);
    check("clamp_y0",   32'(o_y), 32'd0);

    // all buttons, then rejected status (bit3 clear) holds them
    good(8'h0F, 8'h00, 8'h00);
    check("btn_all",   32'(o_buttons), 32'd7);
    good(8'h01, 8'h00, 8'h00);
    check("bit3_err",  32'(o_error), 32'd1);
    check("bit3_cnt",  32'(o_err_cnt), 32'd2);
    check("bit3_btn",  32'(o_buttons), 32'd7);

    // bad start bit on word3, bad stop bit on word1
    pkt(fr(8'h08), fr(8'h00), fr(8'h01) | 11'h400, fr(8'h00));
    check("start_err", 32'(o_error), 32'd1);
    check("start_cnt", 32'(o_err_cnt), 32'd3);
    pkt(fr(8'h08) & 11'h7FE, fr(8'h00), fr(8'h00), fr(8'h00));
    check("stop_err",  32'(o_error), 32'd1);
    check("stop_cnt",  32'(o_err_cnt), 32'd4);

    // wheel: nibble 0xF (-1) twice
    pkt(fr(8'h08), fr(8'h00), fr(8'h00), fr(8'h0F));
    check("z_1", 32'(o_z), WHEEL ? 32'hFF : 32'h00);
    pkt(fr(8'h08), fr(8'h00), fr(8'h00), fr(8'h0F));
    check("z_2", 32'(o_z), WHEEL ? 32'hFE : 32'h00);
    check("z_valid", 32'(o_valid), 32'd1);

    // bad word4 frame with dx=-1: rejected only when wheel is enabled
    pkt(fr(8'h18), fr(8'hFF), fr(8'h00), fr(8'h01) ^ 11'h002);
    exp_x   = WHEEL ? 10'd639 : 10'd638;
    exp_cnt = WHEEL ? 8'd5 : 8'd4;
    check("w4_x",     32'(o_x), 32'(exp_x));
    check("w4_cnt",   32'(o_err_cnt), 32'(exp_cnt));
    check("w4_valid", 32'(o_valid), WHEEL ? 32'd0 : 32'd1);

    // strobe during CHECK is dropped; in-flight packet (dx=-2) still completes
    @(negedge clk);
    w1 = fr(8'h18); w2 = fr(8'hFE); w3 = fr(8'h00); w4 = fr(8'h00); rdy = 1'b1;
    @(negedge clk);
    w2 = fr(8'h7F);
    @(negedge clk);
    rdy = 1'b0;
    check("drop_err",   32'(o_error), 32'd1);
    check("drop_valid", 32'(o_valid), 32'd0);
    check("drop_cnt",   32'(o_err_cnt), 32'(exp_cnt + 8'd1));
    @(posedge clk); #1;
    check("drop_pkt_valid", 32'(o_valid), 32'd1);
    check("drop_pkt_err",   32'(o_error), 32'd0);
    check("drop_pkt_x",     32'(o_x), 32'(exp_x - 10'd2));

    // reset in CHECK aborts the packet
    @(negedge clk);
    w1 = fr(8'h09); w2 = fr(8'h01); w3 = fr(8'h01); rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_x",   32'(o_x), 32'd320);
    check("mid_rst_y",   32'(o_y), 32'd240);
    check("mid_rst_cnt", 32'(o_err_cnt), 32'd0);
    check("mid_rst_z",   32'(o_z), 32'd0);
    check("mid_rst_st",  32'(dbg_state), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | o_valid | o_error;
    end
    check("mid_rst_quiet", 32'(seen), 32'd0);
    check("mid_rst_btn",   32'(o_buttons), 32'd0);

    // error counter saturation
    for (int i = 0; i < 256; i++) pkt(fr(8'h00), fr(8'h00), fr(8'h00), fr(8'h00));
    check("sat_255", 32'(o_err_cnt), 32'd255);
    pkt(fr(8'h00), fr(8'h00), fr(8'h00), fr(8'h00));
    check("sat_hold",  32'(o_err_cnt), 32'd255);
    check("sat_pulse", 32'(o_error), 32'd1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
